// File: rtl/vga_pkg.sv
// Shared timing constants for the VGA timing generator (800x600@72 defaults)
// and the helper that sizes counters from a period length.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 56;
    localparam int H_SYNC_DEF   = 120;
    localparam int H_BP_DEF     = 64;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF     = 37;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 23;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Bits needed to count 0..total-1, never narrower than one bit.
    function automatic int width_of(input int total);
        if (total <= 2) begin
            return 1;
        end else begin
            return $clog2(total);
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One wrapping timing axis (horizontal or vertical): position counter with
// carry-out plus combinational sync-window and active-region decodes.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = width_of(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_sync,
    output logic         in_active
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);

    logic [W-1:0] count_r;

    assign count     = count_r;
    assign wrap      = inc && (count_r == LAST);
    assign in_sync   = (count_r >= SYNC_FIRST) && (count_r <= SYNC_LAST);
    assign in_active = (count_r < ACT_END);

    // Position counter: advances on inc, returns to zero after the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            if (wrap) begin
                count_r <= {W{1'b0}};
            end else begin
                count_r <= count_r + W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, h/v axis counters and a
// single output register stage so every output is aligned one clk after its state.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int ADDR_SHIFT = 2,
    parameter int ADDR_W     = 8,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W       = width_of(H_TOTAL),
    localparam int Y_W       = width_of(V_TOTAL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    output logic                h_sync_o,
    output logic                v_sync_o,
    output logic                in_disp_o,
    output logic [X_W-1:0]      x_o,
    output logic [Y_W-1:0]      y_o,
    output logic [2*ADDR_W-1:0] pixel_pos_o,
    output logic                pix_en_o,
    output logic                line_start_o,
    output logic                frame_start_o
);

    localparam int DIV_W = width_of(CLK_DIV);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: timing widths must be non-zero and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0]      div_r;
    logic                  div_zero_s;
    logic                  pix_tick_s;
    logic [X_W-1:0]        h_count_s;
    logic [Y_W-1:0]        v_count_s;
    logic                  h_wrap_s, h_sync_act_s, h_active_s;
    logic                  v_wrap_s, v_sync_act_s, v_active_s;
    logic [X_W+ADDR_W-1:0] x_ext_s;
    logic [Y_W+ADDR_W-1:0] y_ext_s;
    logic                  unused_s;

    assign div_zero_s = (div_r == {DIV_W{1'b0}});
    assign pix_tick_s = en_i && (div_r == DIV_W'(CLK_DIV - 1));

    // Zero-extend before shifting so coordinates narrower than ADDR_W still fill the field.
    assign x_ext_s  = {{ADDR_W{1'b0}}, h_count_s} >> ADDR_SHIFT;
    assign y_ext_s  = {{ADDR_W{1'b0}}, v_count_s} >> ADDR_SHIFT;
    assign unused_s = v_wrap_s;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .inc       (pix_tick_s),
        .count     (h_count_s),
        .wrap      (h_wrap_s),
        .in_sync   (h_sync_act_s),
        .in_active (h_active_s)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .inc       (h_wrap_s),
        .count     (v_count_s),
        .wrap      (v_wrap_s),
        .in_sync   (v_sync_act_s),
        .in_active (v_active_s)
    );

    // Pixel-period divider: counts enabled clocks within one pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
        end else if (pix_tick_s) begin
            div_r <= {DIV_W{1'b0}};
        end else if (en_i) begin
            div_r <= div_r + DIV_W'(1);
        end else begin
            div_r <= div_r;
        end
    end

    // Output stage: decode the current state; while disabled, strobes drop and the rest hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_sync_o      <= ~H_SYNC_POL;
            v_sync_o      <= ~V_SYNC_POL;
            in_disp_o     <= 1'b0;
            x_o           <= {X_W{1'b0}};
            y_o           <= {Y_W{1'b0}};
            pixel_pos_o   <= {(2*ADDR_W){1'b0}};
            pix_en_o      <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (en_i) begin
            h_sync_o      <= h_sync_act_s ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_o      <= v_sync_act_s ? V_SYNC_POL : ~V_SYNC_POL;
            in_disp_o     <= h_active_s && v_active_s;
            x_o           <= h_count_s;
            y_o           <= v_count_s;
            pixel_pos_o   <= {y_ext_s[ADDR_W-1:0], x_ext_s[ADDR_W-1:0]};
            pix_en_o      <= div_zero_s;
            line_start_o  <= div_zero_s && (h_count_s == {X_W{1'b0}});
            frame_start_o <= div_zero_s && (h_count_s == {X_W{1'b0}}) && (v_count_s == {Y_W{1'b0}});
        end else begin
            pix_en_o      <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 800x600 instance and a tiny
// CLK_DIV=2 instance, both checked against a time-based raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs, vs, disp, pe, ls, fs;
        logic [15:0] x, y, pos;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic        h0, v0, d0, pe0, ls0, fs0;
    logic [10:0] x0;
    logic [9:0]  y0;
    logic [15:0] pos0;
    logic        h1, v1, d1, pe1, ls1, fs1;
    logic [3:0]  x1;
    logic [2:0]  y1;
    logic [15:0] pos1;

    int     cmp = 0;
    int     bad = 0;
    longint cyc = 0;

    int P_HA[2]  = '{800, 8};
    int P_HF[2]  = '{56, 2};
    int P_HS[2]  = '{120, 2};
    int P_HB[2]  = '{64, 2};
    int P_VA[2]  = '{600, 4};
    int P_VF[2]  = '{37, 1};
    int P_VS[2]  = '{6, 1};
    int P_VB[2]  = '{23, 1};
    int P_DIV[2] = '{1, 2};
    bit P_HPOL[2] = '{1'b0, 1'b1};
    bit P_VPOL[2] = '{1'b0, 1'b0};

    longint t_m[2];
    out_t   exp_m[2];
    out_t   obs0, obs1;

    assign obs0 = {h0, v0, d0, pe0, ls0, fs0, 16'(x0), 16'(y0), pos0};
    assign obs1 = {h1, v1, d1, pe1, ls1, fs1, 16'(x1), 16'(y1), pos1};

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .en_i(en),
        .h_sync_o(h0), .v_sync_o(v0), .in_disp_o(d0), .x_o(x0), .y_o(y0),
        .pixel_pos_o(pos0), .pix_en_o(pe0), .line_start_o(ls0), .frame_start_o(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CLK_DIV(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .en_i(en),
        .h_sync_o(h1), .v_sync_o(v1), .in_disp_o(d1), .x_o(x1), .y_o(y1),
        .pixel_pos_o(pos1), .pix_en_o(pe1), .line_start_o(ls1), .frame_start_o(fs1)
    );

    // Raster position derived purely from the number of enabled clocks since reset.
    function automatic out_t calc(input int i, input longint t);
        out_t   o;
        longint p;
        int     x, y, ht, vt, hs_first, vs_first;
        ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        p  = t / P_DIV[i];
        x  = int'(p % ht);
        y  = int'((p / ht) % vt);
        hs_first = P_HA[i] + P_HF[i];
        vs_first = P_VA[i] + P_VF[i];
        o.hs   = (x >= hs_first && x < hs_first + P_HS[i]) ? P_HPOL[i] : ~P_HPOL[i];
        o.vs   = (y >= vs_first && y < vs_first + P_VS[i]) ? P_VPOL[i] : ~P_VPOL[i];
        o.disp = (x < P_HA[i]) && (y < P_VA[i]);
        o.pe   = ((t % P_DIV[i]) == 0);
        o.ls   = o.pe && (x == 0);
        o.fs   = o.ls && (y == 0);
        o.x    = 16'(x);
        o.y    = 16'(y);
        o.pos  = {8'(y >> 2), 8'(x >> 2)};
        return o;
    endfunction

    function automatic out_t reset_val(input int i);
        out_t o;
        o    = '0;
        o.hs = ~P_HPOL[i];
        o.vs = ~P_VPOL[i];
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                exp_m[i] = reset_val(i);
                t_m[i]   = 0;
            end else if (en) begin
                exp_m[i] = calc(i, t_m[i]);
                t_m[i]++;
            end else begin
                exp_m[i].pe = 1'b0;
                exp_m[i].ls = 1'b0;
                exp_m[i].fs = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) step();
        cmp++;
        if (obs0 !== exp_m[0]) begin bad++; $display("FAIL reset_dut0: got %h expected %h", obs0, exp_m[0]); end
        cmp++;
        if (obs1 !== exp_m[1]) begin bad++; $display("FAIL reset_dut1: got %h expected %h", obs1, exp_m[1]); end
    endtask

    task automatic test_release();
        rst = 1'b0;
        en  = 1'b1;
        step();
        cmp++;
        if (obs0 !== exp_m[0]) begin bad++; $display("FAIL release_model0: got %h expected %h", obs0, exp_m[0]); end
        cmp++;
        if ({fs0, ls0, pe0, d0, x0, y0} !== {4'b1111, 11'd0, 10'd0})
            begin bad++; $display("FAIL release_dut0: got %b%b%b%b x=%0d y=%0d expected 1111 x=0 y=0", fs0, ls0, pe0, d0, x0, y0); end
        cmp++;
        if ({fs1, ls1, pe1, d1, x1, y1} !== {4'b1111, 4'd0, 3'd0})
            begin bad++; $display("FAIL release_dut1: got %b%b%b%b x=%0d y=%0d expected 1111 x=0 y=0", fs1, ls1, pe1, d1, x1, y1); end
    endtask

    task automatic test_line_timing();
        longint ls_q[$];
        int hs_cnt = 0, hs_min = 99999, hs_max = -1, disp_cnt = 0;
        longint period;
        en = 1'b1;
        do_reset();
        for (int k = 0; k < 2 * 1040 + 4; k++) begin
            step();
            cmp++;
            if (obs0 !== exp_m[0]) begin bad++; $display("FAIL line_model0: got %h expected %h", obs0, exp_m[0]); end
            if (ls0) ls_q.push_back(cyc);
            if (ls_q.size() == 1) begin
                if (!h0) begin
                    hs_cnt++;
                    if (int'(x0) < hs_min) hs_min = int'(x0);
                    if (int'(x0) > hs_max) hs_max = int'(x0);
                end
                if (d0) disp_cnt++;
            end
        end
        period = (ls_q.size() >= 2) ? ls_q[1] - ls_q[0] : -1;
        cmp++; if (period != 1040) begin bad++; $display("FAIL line_period: got %0d expected 1040", period); end
        cmp++; if (hs_cnt != 120) begin bad++; $display("FAIL hsync_len: got %0d expected 120", hs_cnt); end
        cmp++; if (hs_min != 856) begin bad++; $display("FAIL hsync_first_x: got %0d expected 856", hs_min); end
        cmp++; if (hs_max != 975) begin bad++; $display("FAIL hsync_last_x: got %0d expected 975", hs_max); end
        cmp++; if (disp_cnt != 800) begin bad++; $display("FAIL disp_per_line: got %0d expected 800", disp_cnt); end
    endtask

    task automatic test_pixel_pos();
        bit seen0 = 1'b0, found = 1'b0;
        en = 1'b1;
        do_reset();
        for (int k = 0; k < 8000; k++) begin
            step();
            if (x0 == 11'd799 && y0 == 10'd0 && !seen0) begin
                seen0 = 1'b1;
                cmp++;
                if (pos0 !== {8'd0, 8'd199}) begin bad++; $display("FAIL pos_799_0: got %h expected %h", pos0, {8'd0, 8'd199}); end
            end
            if (x0 == 11'd799 && y0 == 10'd5) begin
                found = 1'b1;
                cmp++;
                if (pos0 !== {8'd1, 8'd199}) begin bad++; $display("FAIL pos_799_5: got %h expected %h", pos0, {8'd1, 8'd199}); end
                break;
            end
        end
        if (!found) begin cmp++; bad++; $display("FAIL pos_timeout: got no (799,5) expected it within 8000 clk"); end
    endtask

    task automatic test_small_frame();
        longint fs_q[$], ls_q[$];
        int hs_cnt = 0, hs_min = 99, hs_max = -1, vs_cnt = 0, vs_min = 99, vs_max = -1, disp_cnt = 0;
        logic prev_pe = 1'b0;
        longint fper, lper;
        en = 1'b1;
        do_reset();
        for (int k = 0; k < 2 * 196 + 4; k++) begin
            step();
            cmp++;
            if (obs1 !== exp_m[1]) begin bad++; $display("FAIL small_model1: got %h expected %h", obs1, exp_m[1]); end
            if (k > 0) begin
                cmp++;
                if (pe1 === prev_pe) begin bad++; $display("FAIL pix_en_alt: got %b expected %b", pe1, ~prev_pe); end
            end
            prev_pe = pe1;
            if (fs1) fs_q.push_back(cyc);
            if (ls1) ls_q.push_back(cyc);
            if (fs_q.size() == 1) begin
                if (h1) begin
                    hs_cnt++;
                    if (int'(x1) < hs_min) hs_min = int'(x1);
                    if (int'(x1) > hs_max) hs_max = int'(x1);
                end
                if (!v1) begin
                    vs_cnt++;
                    if (int'(y1) < vs_min) vs_min = int'(y1);
                    if (int'(y1) > vs_max) vs_max = int'(y1);
                end
                if (d1) disp_cnt++;
            end
        end
        fper = (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1;
        lper = (ls_q.size() >= 2) ? ls_q[1] - ls_q[0] : -1;
        cmp++; if (fper != 196) begin bad++; $display("FAIL small_frame_period: got %0d expected 196", fper); end
        cmp++; if (lper != 28) begin bad++; $display("FAIL small_line_period: got %0d expected 28", lper); end
        cmp++; if (hs_cnt != 28) begin bad++; $display("FAIL small_hsync_clk: got %0d expected 28", hs_cnt); end
        cmp++; if (hs_min != 10 || hs_max != 11) begin bad++; $display("FAIL small_hsync_x: got %0d..%0d expected 10..11", hs_min, hs_max); end
        cmp++; if (vs_cnt != 28) begin bad++; $display("FAIL small_vsync_clk: got %0d expected 28", vs_cnt); end
        cmp++; if (vs_min != 5 || vs_max != 5) begin bad++; $display("FAIL small_vsync_y: got %0d..%0d expected 5..5", vs_min, vs_max); end
        cmp++; if (disp_cnt != 64) begin bad++; $display("FAIL small_disp_clk: got %0d expected 64", disp_cnt); end
    endtask

    task automatic test_en_pause();
        longint first_ls = -1;
        bit found = 1'b0;
        en = 1'b1;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step();
            if (ls0 && first_ls < 0) first_ls = cyc;
            if (x0 == 11'd100) begin found = 1'b1; break; end
        end
        if (!found) begin cmp++; bad++; $display("FAIL pause_timeout: got no x=100 expected it within 300 clk"); end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            cmp++;
            if ({x0, pe0, ls0, fs0} !== {11'd100, 3'b000})
                begin bad++; $display("FAIL pause_hold: got x=%0d strobes=%b%b%b expected x=100 strobes=000", x0, pe0, ls0, fs0); end
            cmp++;
            if (obs0 !== exp_m[0]) begin bad++; $display("FAIL pause_model0: got %h expected %h", obs0, exp_m[0]); end
        end
        en = 1'b1;
        step();
        cmp++;
        if (x0 !== 11'd101) begin bad++; $display("FAIL pause_resume: got %0d expected 101", x0); end
        found = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            step();
            if (ls0) begin found = 1'b1; break; end
        end
        cmp++;
        if (!found || (cyc - first_ls) != 1050)
            begin bad++; $display("FAIL pause_line_delay: got %0d expected 1050", found ? cyc - first_ls : -1); end
    endtask

    task automatic test_midframe_reset();
        bit found = 1'b0;
        en = 1'b1;
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            step();
            if (x0 == 11'd500 && y0 == 10'd1) begin found = 1'b1; break; end
        end
        if (!found) begin cmp++; bad++; $display("FAIL midreset_timeout: got no (500,1) expected it within 2000 clk"); end
        rst = 1'b1;
        step();
        cmp++;
        if ({x0, y0, pos0, d0, pe0, ls0, fs0, h0, v0} !== {11'd0, 10'd0, 16'd0, 4'b0000, 2'b11})
            begin bad++; $display("FAIL midreset_vals: got x=%0d y=%0d pos=%h flags=%b%b%b%b%b%b expected zeros, syncs 11", x0, y0, pos0, d0, pe0, ls0, fs0, h0, v0); end
        cmp++;
        if (obs1 !== exp_m[1]) begin bad++; $display("FAIL midreset_model1: got %h expected %h", obs1, exp_m[1]); end
        rst = 1'b0;
        step();
        cmp++;
        if ({fs0, x0, y0} !== {1'b1, 11'd0, 10'd0})
            begin bad++; $display("FAIL midreset_restart: got fs=%b x=%0d y=%0d expected fs=1 x=0 y=0", fs0, x0, y0); end
    endtask

    task automatic test_random();
        en = 1'b1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
            cmp++;
            if (obs0 !== exp_m[0]) begin bad++; $display("FAIL random_dut0: got %h expected %h", obs0, exp_m[0]); end
            cmp++;
            if (obs1 !== exp_m[1]) begin bad++; $display("FAIL random_dut1: got %h expected %h", obs1, exp_m[1]); end
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_release();
        test_line_timing();
        test_pixel_pos();
        test_small_frame();
        test_en_pause();
        test_midframe_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
